// File: rtl/bist_address_sequencer_if.sv
// Bus bundle between the March-element controller (master) and the BIST
// address sequencer (slave): sweep control in, current address and status out.
interface bist_address_sequencer_if #(
    parameter int A_WIDTH = 4
);
    logic               start;
    logic               abort;
    logic               adv;
    logic               up_down;
    logic               fast_row;
    logic [A_WIDTH-1:0] lo_addr;
    logic [A_WIDTH-1:0] hi_addr;
    logic [A_WIDTH-1:0] address;
    logic               addr_valid;
    logic               last;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, abort, adv, up_down, fast_row, lo_addr, hi_addr,
        input  address, addr_valid, last, busy, done, err
    );

    modport slave (
        input  start, abort, adv, up_down, fast_row, lo_addr, hi_addr,
        output address, addr_valid, last, busy, done, err
    );
endinterface

// File: rtl/bist_address_sequencer.sv
// Walks an inclusive address window up or down, linear or fast-row order,
// one address per adv; flags the final address and holds done until restart.
module bist_address_sequencer #(
    parameter int A_WIDTH  = 4,
    parameter int COL_BITS = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    bist_address_sequencer_if.slave   bus
);
    localparam int ROW_BITS = A_WIDTH - COL_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] idx_q, idx_d;
    logic [A_WIDTH-1:0] lo_q, lo_d;
    logic [A_WIDTH-1:0] hi_q, hi_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic               dir_q, dir_d;
    logic               frow_q, frow_d;
    logic               err_q, err_d;

    logic [A_WIDTH-1:0] end_idx;
    logic               at_end;
    logic               running;

    // Fast-row order rotates the row field into the low bits.
    function automatic logic [A_WIDTH-1:0] map_addr(
        input logic [A_WIDTH-1:0] i,
        input logic               fr
    );
        logic [A_WIDTH-1:0] r;
        r = fr ? {i[ROW_BITS-1:0], i[A_WIDTH-1:ROW_BITS]} : i;
        return r;
    endfunction

    assign end_idx = dir_q ? hi_q : lo_q;
    assign at_end  = (idx_q == end_idx);
    assign running = (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        dir_d   = dir_q;
        frow_d  = frow_q;
        err_d   = err_q;

        if (bus.abort) begin
            state_d = S_IDLE;
            err_d   = 1'b0;
        end else if (bus.start && !running) begin
            if (bus.lo_addr > bus.hi_addr) begin
                // Illegal window: report and finish without presenting an address.
                state_d = S_DONE;
                err_d   = 1'b1;
            end else begin
                state_d = S_RUN;
                err_d   = 1'b0;
                lo_d    = bus.lo_addr;
                hi_d    = bus.hi_addr;
                dir_d   = bus.up_down;
                frow_d  = bus.fast_row;
                idx_d   = bus.up_down ? bus.lo_addr : bus.hi_addr;
            end
        end else if (bus.adv && running) begin
            if (at_end) begin
                state_d = S_DONE;
            end else begin
                idx_d = dir_q ? idx_q + A_WIDTH'(1) : idx_q - A_WIDTH'(1);
            end
        end

        addr_d = map_addr(idx_d, frow_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            dir_q   <= 1'b0;
            frow_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            dir_q   <= dir_d;
            frow_q  <= frow_d;
            err_q   <= err_d;
        end
    end

    assign bus.address    = addr_q;
    assign bus.addr_valid = running;
    assign bus.busy       = running;
    assign bus.last       = running && at_end;
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_bist_address_sequencer.sv
// Directed and random stimulus against a queue-based sweep model.
module tb_bist_address_sequencer;
    localparam int AW   = 4;
    localparam int COLB = 2;
    localparam int ROWB = AW - COLB;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bist_address_sequencer_if #(.A_WIDTH(AW)) bus ();

    bist_address_sequencer #(.A_WIDTH(AW), .COL_BITS(COLB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: remaining addresses of the sweep, front is current.
    int q[$];
    bit m_active;
    int m_addr;
    bit m_done;
    bit m_err;

    function automatic int map(int i, bit fr);
        if (fr) return ((i % (1 << ROWB)) << COLB) | (i >> ROWB);
        return i;
    endfunction

    task automatic model_reset();
        q.delete();
        m_active = 0;
        m_addr   = 0;
        m_done   = 0;
        m_err    = 0;
    endtask

    task automatic model_step(bit s, bit ab, bit a, bit ud, bit fr, int lo, int hi);
        if (ab) begin
            m_active = 0;
            m_done   = 0;
            m_err    = 0;
            q.delete();
        end else if (s && !m_active) begin
            if (lo > hi) begin
                m_err  = 1;
                m_done = 1;
            end else begin
                q.delete();
                if (ud) for (int i = lo; i <= hi; i++) q.push_back(map(i, fr));
                else    for (int i = hi; i >= lo; i--) q.push_back(map(i, fr));
                m_active = 1;
                m_done   = 0;
                m_err    = 0;
                m_addr   = q[0];
            end
        end else if (a && m_active) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
                m_active = 0;
                m_done   = 1;
            end else begin
                m_addr = q[0];
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".address"},    32'(bus.address),    32'(m_addr));
        chk({tag, ".addr_valid"}, 32'(bus.addr_valid), 32'(m_active));
        chk({tag, ".busy"},       32'(bus.busy),       32'(m_active));
        chk({tag, ".last"},       32'(bus.last),       32'(m_active && q.size() == 1));
        chk({tag, ".done"},       32'(bus.done),       32'(m_done));
        chk({tag, ".err"},        32'(bus.err),        32'(m_err));
    endtask

    task automatic set_in(bit s, bit ab, bit a, bit ud, bit fr, int lo, int hi);
        bus.start    = s;
        bus.abort    = ab;
        bus.adv      = a;
        bus.up_down  = ud;
        bus.fast_row = fr;
        bus.lo_addr  = AW'(lo);
        bus.hi_addr  = AW'(hi);
    endtask

    task automatic tick(string tag);
        bit s, ab, a, ud, fr;
        int lo, hi;
        s  = bus.start;   ab = bus.abort;    a  = bus.adv;
        ud = bus.up_down; fr = bus.fast_row;
        lo = int'(bus.lo_addr);
        hi = int'(bus.hi_addr);
        @(posedge clk);
        model_step(s, ab, a, ud, fr, lo, hi);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #3;
        model_reset();
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Ascending linear 3..6 with adv held high.
        set_in(1, 0, 1, 1, 0, 3, 6);
        tick("asc_start");
        set_in(0, 0, 1, 1, 0, 3, 6);
        repeat (4) tick("asc");
        chk("asc_hold_addr", 32'(bus.address), 32'd6);
        chk("asc_done", 32'(bus.done), 32'd1);

        // Full-range descending.
        set_in(1, 0, 1, 0, 0, 0, 15);
        tick("full_dn_start");
        set_in(0, 0, 1, 0, 0, 0, 15);
        repeat (16) tick("full_dn");
        chk("full_dn_end_addr", 32'(bus.address), 32'd0);
        tick("full_dn_idle");

        // Fast-row order 0..5.
        set_in(1, 0, 0, 1, 1, 0, 5);
        tick("frow_start");
        set_in(0, 0, 1, 1, 1, 0, 5);
        repeat (6) tick("frow");

        // Stall pattern.
        set_in(1, 0, 0, 1, 0, 1, 4);
        tick("stall_start");
        set_in(0, 0, 1, 1, 0, 1, 4); tick("stall_a1");
        set_in(0, 0, 0, 1, 0, 1, 4); tick("stall_a0");
        tick("stall_a0b");
        chk("stall_hold", 32'(bus.address), 32'd2);
        set_in(0, 0, 1, 1, 0, 1, 4);
        repeat (3) tick("stall_rest");

        // Illegal bounds.
        set_in(1, 0, 1, 1, 0, 9, 2);
        tick("illegal");
        set_in(0, 0, 1, 1, 0, 9, 2);
        repeat (3) tick("illegal_hold");
        chk("illegal_err", 32'(bus.err), 32'd1);

        // Single-address window.
        set_in(1, 0, 0, 0, 0, 10, 10);
        tick("single_start");
        chk("single_last", 32'(bus.last), 32'd1);
        set_in(0, 0, 1, 0, 0, 10, 10);
        tick("single_end");

        // Abort with adv at address 5.
        set_in(1, 0, 0, 1, 0, 2, 9);
        tick("abort_start");
        set_in(0, 0, 1, 1, 0, 2, 9);
        repeat (3) tick("abort_run");
        set_in(0, 1, 1, 1, 0, 2, 9);
        tick("abort");
        chk("abort_addr", 32'(bus.address), 32'd5);
        chk("abort_done", 32'(bus.done), 32'd0);

        // Start in DONE together with adv.
        set_in(1, 0, 1, 1, 0, 0, 1);
        tick("d2_start");
        set_in(0, 0, 1, 1, 0, 0, 1);
        repeat (2) tick("d2_run");
        set_in(1, 0, 1, 0, 0, 12, 13);
        tick("restart_from_done");
        chk("restart_addr", 32'(bus.address), 32'd13);

        // Reset mid-sweep at address 7, then immediate restart.
        set_in(1, 0, 0, 1, 0, 4, 12);
        tick("rst_start");
        set_in(0, 0, 1, 1, 0, 4, 12);
        repeat (3) tick("rst_run");
        set_in(0, 0, 0, 1, 0, 4, 12);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        reset_n = 1'b1;
        set_in(1, 0, 0, 1, 0, 4, 12);
        tick("rst_release_start");

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            set_in($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
                   $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bist_address_sequencer.md
# bist_address_sequencer

Programmable address sequencer for the BIST memory-test path. Walks a bounded address window up or down, in fast-column (linear) or fast-row order, one address per advance request, and flags the last address and sweep completion. It is the parametrised successor to the free-running BIST up/down address counter and is driven by the March-element controller.

## Interface

**Parameters**
- `A_WIDTH`, default 4: address width. Must be ≥ 2.
- `COL_BITS`, default 2: column field width. Range 1..A_WIDTH-1.
  - `ROW_BITS = A_WIDTH - COL_BITS`.
  - Address layout is `{row, col}`.

**Ports**
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: sweep request pulse. Accepted only in IDLE or DONE.
- `abort`  in  1: return to IDLE from any state.
- `adv`  in  1: consume the current address and step to the next one.
- `up_down`  in  1: 1 = ascending, 0 = descending. Sampled at `start`.
- `fast_row`  in  1: 1 = row field toggles fastest. Sampled at `start`.
- `lo_addr`  in  A_WIDTH: window lower bound, inclusive, in index space. Sampled at `start`.
- `hi_addr`  in  A_WIDTH: window upper bound, inclusive, in index space. Sampled at `start`.
- `address`  out  A_WIDTH: current address, registered.
- `addr_valid`  out  1: `address` is valid.
- `last`  out  1: current address is the final one of the sweep.
- `busy`  out  1: state is RUN.
- `done`  out  1: sweep has finished. Level, held until `start` or `abort`.
- `err`  out  1: the last accepted `start` had `lo_addr > hi_addr`.

## Operation

**Registers**
- Internal index counter `idx` (A_WIDTH bits).
- Latched configuration: `lo`, `hi`, `dir`, `frow`.

**Address mapping**
- `fast_row` = 0: `address = idx`.
- `fast_row` = 1: `address = {idx[ROW_BITS-1:0], idx[A_WIDTH-1:ROW_BITS]}`.

**States**

IDLE
- Outputs: `addr_valid` = 0, `busy` = 0, `done` = 0.
- On `start` with `lo_addr <= hi_addr`:
  - Latch the configuration.
  - `idx` ← `lo_addr` if ascending, `hi_addr` if descending.
  - Clear `err`. Go to RUN.
- On `start` with `lo_addr > hi_addr`:
  - Set `err` = 1, `done` = 1. Go to DONE. `addr_valid` stays 0.

RUN
- `addr_valid` = 1, `busy` = 1.
- Define `end_idx` = `hi` if ascending, else `lo`.
- `last = addr_valid && (idx == end_idx)`. Combinational from registered state.
- `adv` with `idx != end_idx`: `idx` ← `idx + 1` (ascending) or `idx - 1` (descending).
- `adv` with `idx == end_idx`: go to DONE.
  - `addr_valid` ← 0, `done` ← 1.
  - `idx` holds, so `address` keeps the final address.
- `start` is ignored.

DONE
- `addr_valid` = 0, `done` = 1.
- `start` behaves exactly as in IDLE: a new sweep is launched directly and `done` clears in the same edge.

**Priority**
- `abort` > `start` > `adv`.
- `abort` in any state: go to IDLE, clear `done` and `err`, `addr_valid` ← 0. `idx` holds.

**Arithmetic**
- Sweep length is `hi - lo + 1` addresses, from 1 to 2^A_WIDTH.
- `idx` never leaves `[lo, hi]`, so no modular wrap occurs inside a sweep.
- A full window `lo = 0`, `hi = 2^A_WIDTH - 1` ends at the boundary without overflow.
- A full descending sweep ends at 0 without underflow.

**Reset**
- `address` = 0, `idx` = 0, `addr_valid` = 0, `last` = 0, `busy` = 0, `done` = 0, `err` = 0.
- State = IDLE. Latched configuration = 0.

## Timing

- `start` sampled at edge N: first `address` and `addr_valid` = 1 visible after edge N (latency 1).
- Each `adv` sampled at edge k updates `address` after edge k.
  - Full throughput: with `adv` held high, a sweep of L addresses occupies L consecutive cycles with `addr_valid` = 1.
  - `adv` = 0 holds the current address indefinitely.
- `last` is high during the cycle whose `adv` ends the sweep. `done` rises on the following edge.
- `adv` while `addr_valid` = 0 is ignored.
- `start` and `adv` in the same cycle in DONE: `start` wins; the first address of the new sweep is presented.
- `reset_n` asserted mid-sweep: outputs go to reset values immediately, without waiting for a clock edge.
- `reset_n` release: the first `start` is accepted on the first rising edge after release.

## Test plan

All scenarios use A_WIDTH = 4, COL_BITS = 2.

1. Reset mid-sweep: drop `reset_n` while RUN with `address` = 7 → immediately `address` = 0, `addr_valid` = 0, `busy` = 0, `done` = 0, `err` = 0.
2. Ascending linear sweep: `lo` = 3, `hi` = 6, `up_down` = 1, `adv` held high → addresses 3, 4, 5, 6 on consecutive cycles; `last` = 1 only at 6; `done` = 1 on the next cycle with `address` held at 6.
3. Full-range descending sweep: `lo` = 0, `hi` = 15, `up_down` = 0 → addresses 15 down to 0 (16 valid cycles); no wrap to 15; `done` asserts after 0.
4. Fast-row order: `lo` = 0, `hi` = 5, `fast_row` = 1, ascending → addresses 0, 4, 8, 12, 1, 5.
5. Stall, illegal bounds and single-address window:
   - Toggle `adv` 1,0,0,1 during a sweep → `address` holds during the 0 cycles.
   - `start` with `lo` = 9, `hi` = 2 → `err` = 1, `done` = 1, `addr_valid` never asserts.
   - `lo` = `hi` = 10 → one address, 10, with `last` = 1.
6. Abort and restart:
   - `abort` together with `adv` at address 5 → IDLE next cycle, `address` = 5, `done` = 0.
   - `start` in DONE together with `adv` → new sweep's first address; `done` clears on the same edge.
